oam_dma_controller: RTL and testbench

Sprite-RAM DMA engine for the $4014 (OAMDMA) register. On a CPU write to $4014 it halts the CPU, takes the CPU bus, and copies 256 bytes from CPU page `{data, 8'h00}` into OAM through repeated writes to $2004 (OAMDATA). It sits directly upstream of SpriteHandler's OAM write path, on the CPU side of the PPU register interface, and is clocked at CPU-cycle rate via `clock_EN`.

---
 rtl/ppu_pkg.sv | 16 +
 rtl/oam_dma_controller.sv | 90 +++++++++
 tb/tb_oam_dma_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding and the register
// addresses that the DMA engine and the PPU register decoder agree on.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// $4014 sprite DMA: halts the CPU and copies page {data,8'h00} into OAM
// through 256 read/write pairs aimed at OAMDATA, one CPU cycle per clock_EN.
module oam_dma_controller #(
  parameter logic [15:0] OAMDMA_ADDR  = ppu_pkg::OAMDMA_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = ppu_pkg::OAMDATA_ADDR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_EN,
  input  logic [15:0] cpuAddress,
  input  logic        cpuRW,
  input  logic [7:0]  cpuData_IN,
  input  logic [7:0]  busData_IN,
  output logic        cpuHalt,
  output logic        dmaBusOwn,
  output logic [15:0] dmaAddress,
  output logic        dmaRW,
  output logic [7:0]  dmaData_OUT,
  output logic        dmaBusy
);

  ppu_pkg::dma_state_t state_q, state_d;
  logic       parity_q;
  logic [7:0] index_q, index_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ppu_pkg::IDLE;
      parity_q <= 1'b0;
      index_q  <= 8'h00;
      page_q   <= 8'h00;
      latch_q  <= 8'h00;
    end else if (clock_EN) begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      index_q  <= index_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    page_d  = page_q;
    latch_d = latch_q;
    case (state_q)
      ppu_pkg::IDLE: begin
        if (cpuAddress == OAMDMA_ADDR && !cpuRW) begin
          page_d  = cpuData_IN;
          index_d = 8'h00;
          state_d = ppu_pkg::HALT;
        end
      end
      // parity_q=1 now means the following cycle is a get cycle.
      ppu_pkg::HALT:  state_d = parity_q ? ppu_pkg::READ : ppu_pkg::ALIGN;
      ppu_pkg::ALIGN: state_d = ppu_pkg::READ;
      ppu_pkg::READ: begin
        latch_d = busData_IN;
        state_d = ppu_pkg::WRITE;
      end
      ppu_pkg::WRITE: begin
        index_d = index_q + 8'h01;
        state_d = (index_q == 8'hFF) ? ppu_pkg::IDLE : ppu_pkg::READ;
      end
      default: state_d = ppu_pkg::IDLE;
    endcase
  end

  always_comb begin
    cpuHalt     = (state_q != ppu_pkg::IDLE);
    dmaBusy     = (state_q != ppu_pkg::IDLE);
    dmaBusOwn   = 1'b0;
    dmaRW       = 1'b0;
    dmaAddress  = 16'h0000;
    dmaData_OUT = 8'h00;
    if (state_q == ppu_pkg::READ) begin
      dmaBusOwn  = 1'b1;
      dmaRW      = 1'b1;
      dmaAddress = {page_q, index_q};
    end else if (state_q == ppu_pkg::WRITE) begin
      dmaBusOwn   = 1'b1;
      dmaAddress  = OAMDATA_ADDR;
      dmaData_OUT = latch_q;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized bench for oam_dma_controller: a cycle-offset model of the DMA
// timeline is compared against the DUT outputs on every clock.
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset_n, clock_EN, cpuRW;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuData_IN, busData_IN;
  logic        cpuHalt, dmaBusOwn, dmaRW, dmaBusy;
  logic [15:0] dmaAddress;
  logic [7:0]  dmaData_OUT;

  always #5 clock = ~clock;

  oam_dma_controller dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN),
    .cpuAddress(cpuAddress), .cpuRW(cpuRW), .cpuData_IN(cpuData_IN),
    .busData_IN(busData_IN), .cpuHalt(cpuHalt), .dmaBusOwn(dmaBusOwn),
    .dmaAddress(dmaAddress), .dmaRW(dmaRW), .dmaData_OUT(dmaData_OUT),
    .dmaBusy(dmaBusy)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Model: a transfer is "cycle k after trigger"; k=1 halts, the pairs start
  // at k=2 when the trigger cycle had parity 0, else at k=3.
  bit         m_active = 1'b0;
  bit         m_par    = 1'b0;
  int         m_k      = 0;
  int         m_start  = 0;
  logic [7:0] m_page   = 8'h00;
  logic [7:0] m_rd [256];
  bit         chk_on   = 1'b0;
  bit         addr_mode = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_par    = 1'b0;
      m_k      = 0;
    end else if (clock_EN) begin
      if (m_active) begin
        if (m_k >= m_start && ((m_k - m_start) % 2 == 0))
          m_rd[(m_k - m_start) / 2] = busData_IN;
        m_k++;
        if (m_k >= m_start + 512) m_active = 1'b0;
      end else if (cpuAddress == 16'h4014 && cpuRW == 1'b0) begin
        m_active = 1'b1;
        m_k      = 1;
        m_start  = 2 + int'(m_par);
        m_page   = cpuData_IN;
      end
      m_par = ~m_par;
    end
  end

  logic [31:0] exp_v, act_v;
  int          j;

  always @(negedge clock) begin
    if (chk_on) begin
      exp_v = 32'h0;
      if (m_active) begin
        exp_v[27:26] = 2'b11;
        if (m_k >= m_start) begin
          j = m_k - m_start;
          if (j % 2 == 0)
            exp_v[25:0] = {1'b1, 1'b1, m_page, 8'(j / 2), 8'h00};
          else
            exp_v[25:0] = {1'b1, 1'b0, 16'h2004, m_rd[j / 2]};
        end
      end
      act_v = {4'h0, cpuHalt, dmaBusy, dmaBusOwn, dmaRW, dmaAddress, dmaData_OUT};
      check("bus_outputs{halt,busy,own,rw,addr,data}", act_v, exp_v);
    end
  end

  int          halt_cnt, wr_cnt;
  bit          first_pending;
  logic [15:0] first_rd, last_rd;

  task automatic cyc(input bit en, input bit rst_n, input bit custom,
                     input logic [15:0] addr, input bit rw, input logic [7:0] data);
    @(negedge clock);
    clock_EN = en;
    reset_n  = rst_n;
    if (custom) begin
      cpuAddress = addr;
      cpuRW      = rw;
      cpuData_IN = data;
    end else begin
      cpuAddress = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
      cpuRW      = 1'($urandom_range(0, 1));
      cpuData_IN = 8'($urandom);
      if (!m_active && cpuAddress == 16'h4014) cpuRW = 1'b1;
    end
    busData_IN = addr_mode ? dmaAddress[7:0] : 8'($urandom);
    if (en && rst_n && chk_on) begin
      if (cpuHalt) halt_cnt++;
      if (dmaBusOwn && dmaRW) begin
        last_rd = dmaAddress;
        if (first_pending) begin
          first_rd      = dmaAddress;
          first_pending = 1'b0;
        end
      end
      if (dmaBusOwn && !dmaRW) begin
        if (addr_mode) check("page_ff_write_data", 32'(dmaData_OUT), 32'(wr_cnt[7:0]));
        wr_cnt++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 8'h0);
  endtask

  task automatic run_transfer(input logic [7:0] page, input bit trig_par,
                              input bit rand_en, input bit amode);
    int n;
    addr_mode = amode;
    while (m_par != trig_par) idle();
    halt_cnt      = 0;
    wr_cnt        = 0;
    first_pending = 1'b1;
    first_rd      = 16'h0;
    last_rd       = 16'h0;
    cyc(1'b1, 1'b1, 1'b1, 16'h4014, 1'b0, page);
    n = 0;
    while (dmaBusy && n < 5000) begin
      cyc(rand_en ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 8'h0);
      n++;
    end
    check("dma_busy_cleared", 32'(dmaBusy), 32'h0);
    check("halted_enabled_cycles", 32'(halt_cnt), 32'(513 + int'(trig_par)));
    check("oam_write_count", 32'(wr_cnt), 32'd256);
    check("first_read_addr", 32'(first_rd), {16'h0, page, 8'h00});
    check("last_read_addr", 32'(last_rd), {16'h0, page, 8'hFF});
    $display("[TB] dma page=%02h trig_parity=%0d rand_en=%0d halted=%0d writes=%0d last_rd=%04h",
             page, trig_par, rand_en, halt_cnt, wr_cnt, last_rd);
    addr_mode = 1'b0;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    clock_EN   = 1'b0;
    cpuAddress = 16'h0;
    cpuRW      = 1'b1;
    cpuData_IN = 8'h0;
    busData_IN = 8'h0;
    cyc(1'b0, 1'b0, 1'b1, 16'h4014, 1'b0, 8'h55);
    cyc(1'b1, 1'b0, 1'b1, 16'h4014, 1'b0, 8'h55);
    chk_on = 1'b1;
    check("reset_outputs", {cpuHalt, dmaBusy, dmaBusOwn, dmaRW, dmaAddress, dmaData_OUT}, 32'h0);

    run_transfer(8'h02, 1'b0, 1'b0, 1'b0);
    run_transfer(8'h02, 1'b1, 1'b0, 1'b0);
    run_transfer(8'hFF, 1'b0, 1'b0, 1'b1);

    // Reset while reading index $40, then confirm a clean restart.
    while (m_par != 1'b0) idle();
    cyc(1'b1, 1'b1, 1'b1, 16'h4014, 1'b0, 8'h33);
    n = 0;
    while (!(dmaBusOwn && dmaRW && dmaAddress == 16'h3340) && n < 400) begin
      idle();
      n++;
    end
    check("reached_read_index_40", 32'(dmaAddress), 32'h3340);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 8'h0);
    check("mid_reset_outputs", {cpuHalt, dmaBusy, dmaBusOwn, dmaRW, dmaAddress, dmaData_OUT}, 32'h0);
    $display("[TB] reset during read of $3340, outputs cleared");
    idle();
    run_transfer(8'h34, 1'b1, 1'b0, 1'b0);

    run_transfer(8'h7A, 1'b0, 1'b1, 1'b0);
    run_transfer(8'h15, 1'b1, 1'b1, 1'b0);

    cyc(1'b1, 1'b1, 1'b1, 16'h4014, 1'b1, 8'h02);
    idle();
    check("no_trigger_on_read_4014", 32'(cpuHalt), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 16'h4015, 1'b0, 8'h02);
    idle();
    check("no_trigger_on_write_4015", 32'(cpuHalt), 32'h0);
    $display("[TB] non-trigger accesses $4014 read / $4015 write, cpuHalt=%0d", cpuHalt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
